pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V fetch stage.
- Supersedes the fixed 64-bit load-through PC register.
- Holds the current PC, offers it to fetch over a valid/ready handshake, and advances by a fixed increment on each accepted fetch.
- Accepts redirects (branch/jump/trap) with alignment checking, supports halt/resume, and keeps a saturating count of accepted fetches for debug.

Parameters:
- XLEN, 64, PC width in bits (32 or 64).
- RESET_VEC, 0, PC value loaded on reset (XLEN bits, must be aligned to ALIGN).
- INC, 4, increment applied per accepted fetch.
- ALIGN, 4, required redirect alignment in bytes (power of two, >= 2).
- CNT_W, 16, width of the fetch counter.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, synchronous active-high reset.
- pc_o, output, XLEN, current PC presented to fetch.
- pc_valid_o, output, 1, pc_o is valid for fetch.
- pc_ready_i, input, 1, fetch accepts pc_o this cycle.
- redirect_i, input, 1, load a new PC.
- redirect_pc_i, input, XLEN, redirect target.
- halt_i, input, 1, request halt; takes effect at the next edge.
- resume_i, input, 1, leave HALT.
- halted_o, output, 1, FSM is in HALT.
- misalign_o, output, 1, one-cycle pulse: redirect target was rejected.
- misalign_addr_o, output, XLEN, last rejected target (held until the next reject or reset).
- fetch_cnt_o, output, CNT_W, count of accepted fetches, saturating.

Behaviour:
- Reset (rst_i high at an edge):
  - pc_o=RESET_VEC, pc_valid_o=0, halted_o=0, misalign_o=0, misalign_addr_o=0, fetch_cnt_o=0.
  - FSM goes to BOOT.
  - Reset overrides every other input in the same cycle.
- FSM states: BOOT, RUN, HALT.
  - BOOT: pc_valid_o=0 for exactly one cycle after reset deasserts, then RUN. Inputs other than rst_i are ignored in BOOT.
  - RUN: pc_valid_o=1.
  - HALT: pc_valid_o=0, halted_o=1, pc_o frozen.
- Accepted fetch = pc_valid_o and pc_ready_i at a rising edge.
  - pc_o <= pc_o + INC, modulo 2^XLEN; wrap-around is silent, no flag.
  - fetch_cnt_o increments and sticks at all-ones.
- Handshake stability: while pc_valid_o=1 and pc_ready_i=0, pc_o must not change unless a redirect is accepted.
- Redirect, evaluated in RUN and HALT:
  - Aligned (redirect_pc_i mod ALIGN == 0): pc_o <= redirect_pc_i at the next edge. No increment that cycle, even if pc_ready_i=1. The fetch is not counted.
  - Misaligned: pc_o unchanged, misalign_o=1 for exactly the next cycle, misalign_addr_o <= redirect_pc_i. The normal handshake increment still applies that cycle.
  - A redirect in HALT updates pc_o but the FSM stays in HALT.
- Halt:
  - halt_i in RUN → HALT at the next edge.
  - If pc_ready_i is also high that cycle, the fetch is accepted and pc_o increments first.
  - resume_i in HALT → RUN at the next edge.
  - halt_i and resume_i both high in HALT: stay in HALT.
  - resume_i in RUN: ignored.
- Priority within one edge: rst_i > aligned redirect > handshake increment. Halt and misalign reporting are independent of the increment.
- Outputs are registered. No combinational path from any input to pc_o or pc_valid_o.

Test Plan:
- Reset, then pc_ready_i=1 held for 3 cycles, XLEN=64, RESET_VEC=0: pc_valid_o=0 for 1 cycle, then pc_o = 0, 4, 8, 0xC; fetch_cnt_o=3 after the third accept.
- Back-pressure: pc_ready_i=0 for 5 cycles at pc_o=0x10: pc_o stays 0x10, pc_valid_o=1, fetch_cnt_o unchanged.
- Aligned redirect 0xDEAD_BEEF_C001_CAF0 with pc_ready_i=1: next pc_o=0xDEAD_BEEF_C001_CAF0 with no +4; the cycle after, 0xDEAD_BEEF_C001_CAF4.
- Misaligned redirect 0xDEAD_BEEF_C001_CAFE with pc_ready_i=1 at pc_o=0x20:
  - pc_o=0x24, misalign_o=1 for exactly one cycle.
  - misalign_addr_o=0xDEAD_BEEF_C001_CAFE, held afterwards.
- Wrap and saturation, XLEN=32, CNT_W=2, pc_o=0xFFFF_FFFC, 5 accepts: pc_o wraps to 0x0 then 0x4, 0x8…; fetch_cnt_o saturates at 3.
- Halt/resume with mid-op reset:
  - halt_i with pc_ready_i=1 at 0x40: pc_o=0x44, halted_o=1, pc_valid_o=0.
  - Redirect 0x100 while halted: pc_o=0x100, still halted.
  - resume_i: pc_valid_o=1 at 0x100.
  - rst_i asserted during RUN: all outputs return to their reset values at the next edge, with one BOOT cycle before pc_valid_o=1.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the RISC-V fetch stage: holds the PC and offers it
// over valid/ready. It also handles redirects, halt/resume and a saturating fetch count.
module pc_gen #(
  parameter int                XLEN      = 64,
  parameter logic [XLEN-1:0]   RESET_VEC = '0,
  parameter int                INC       = 4,
  parameter int                ALIGN     = 4,
  parameter int                CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  input  logic             pc_ready_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             halted_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  misalign_addr_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  localparam int              ALIGN_B = $clog2(ALIGN);
  localparam logic [XLEN-1:0] INC_X   = XLEN'(INC);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [1:0]       state_p0;
  logic [XLEN-1:0]  pc_p0;
  logic             vld_p0;
  logic             mis_p0;
  logic [XLEN-1:0]  mis_addr_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic active;
  logic aligned;
  logic redir_ok;
  logic redir_bad;
  logic accept;

  // Decode of the current cycle: BOOT ignores everything but reset.
  assign active    = (state_p0 == RUN) || (state_p0 == HALT);
  assign aligned   = (redirect_pc_i[ALIGN_B-1:0] == '0);
  assign redir_ok  = active && redirect_i && aligned;
  assign redir_bad = active && redirect_i && !aligned;
  assign accept    = vld_p0 && pc_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p0    <= BOOT;
      vld_p0      <= 1'b0;
      pc_p0       <= RESET_VEC;
      mis_p0      <= 1'b0;
      mis_addr_p0 <= '0;
      cnt_p0      <= '0;
    end else begin
      mis_p0 <= redir_bad;
      if (redir_bad) begin
        mis_addr_p0 <= redirect_pc_i;
      end

      // An accepted aligned redirect replaces the increment and is not counted.
      if (redir_ok) begin
        pc_p0 <= redirect_pc_i;
      end else if (accept) begin
        pc_p0  <= pc_p0 + INC_X;
        cnt_p0 <= sat_inc(cnt_p0);
      end

      case (state_p0)
        BOOT: begin
          state_p0 <= RUN;
          vld_p0   <= 1'b1;
        end
        RUN: begin
          if (halt_i) begin
            state_p0 <= HALT;
            vld_p0   <= 1'b0;
          end
        end
        HALT: begin
          if (resume_i && !halt_i) begin
            state_p0 <= RUN;
            vld_p0   <= 1'b1;
          end
        end
        default: begin
          state_p0 <= BOOT;
          vld_p0   <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o            = pc_p0;
  assign pc_valid_o      = vld_p0;
  assign halted_o        = (state_p0 == HALT);
  assign misalign_o      = mis_p0;
  assign misalign_addr_o = mis_addr_p0;
  assign fetch_cnt_o     = cnt_p0;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 64-bit instance and a 32-bit wrap/saturation instance
// share one stimulus stream and are each checked against a behavioural model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        pc_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic        resume_i = 1'b0;

  logic [63:0] pc64, maddr64;
  logic        vld64, hlt64, mis64;
  logic [15:0] cnt64;
  logic [31:0] pc32, maddr32;
  logic        vld32, hlt32, mis32;
  logic [1:0]  cnt32;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64), .RESET_VEC(64'h0), .INC(4), .ALIGN(4), .CNT_W(16)) u_dut64 (
    .clk_i(clk), .rst_i(rst_i), .pc_o(pc64), .pc_valid_o(vld64), .pc_ready_i(pc_ready_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
    .resume_i(resume_i), .halted_o(hlt64), .misalign_o(mis64),
    .misalign_addr_o(maddr64), .fetch_cnt_o(cnt64)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .INC(4), .ALIGN(4), .CNT_W(2)) u_dut32 (
    .clk_i(clk), .rst_i(rst_i), .pc_o(pc32), .pc_valid_o(vld32), .pc_ready_i(pc_ready_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i[31:0]), .halt_i(halt_i),
    .resume_i(resume_i), .halted_o(hlt32), .misalign_o(mis32),
    .misalign_addr_o(maddr32), .fetch_cnt_o(cnt32)
  );

  typedef struct {
    bit          booting;
    bit          halted;
    logic [63:0] pc;
    bit          mis;
    logic [63:0] maddr;
    longint      cnt;
    logic [63:0] mask;
    longint      cmax;
    logic [63:0] rvec;
  } model_t;

  typedef struct {
    logic [63:0] pc;
    bit          vld;
    bit          hlt;
    bit          mis;
    logic [63:0] maddr;
    longint      cnt;
  } exp_t;

  model_t m64, m32;
  exp_t   q64[$];
  exp_t   q32[$];
  int     total = 0;
  int     bad = 0;

  function automatic model_t step(input model_t m, input bit rst, input bit rdy,
                                  input bit rd, input logic [63:0] rpc,
                                  input bit hlt, input bit res);
    model_t n = m;
    logic [63:0] tgt = rpc & m.mask;
    bit fetch;
    bit jump;
    if (rst) begin
      n.booting = 1; n.halted = 0; n.pc = m.rvec; n.mis = 0; n.maddr = 0; n.cnt = 0;
      return n;
    end
    n.mis = 0;
    if (m.booting) begin
      n.booting = 0;
      return n;
    end
    fetch = !m.halted && rdy;
    jump  = rd && (tgt % 4 == 0);
    if (jump) n.pc = tgt;
    else begin
      if (rd) begin n.mis = 1; n.maddr = tgt; end
      if (fetch) begin
        n.pc  = (m.pc + 64'd4) & m.mask;
        n.cnt = (m.cnt < m.cmax) ? m.cnt + 1 : m.cmax;
      end
    end
    if (!m.halted && hlt) n.halted = 1;
    else if (m.halted && res && !hlt) n.halted = 0;
    return n;
  endfunction

  function automatic exp_t view(input model_t m);
    exp_t e;
    e.pc = m.pc; e.vld = !m.booting && !m.halted; e.hlt = m.halted;
    e.mis = m.mis; e.maddr = m.maddr; e.cnt = m.cnt;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit rdy, input bit rd, input logic [63:0] rpc,
                     input bit hlt, input bit res);
    rst_i = rst; pc_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc;
    halt_i = hlt; resume_i = res;
    @(posedge clk);
    m64 = step(m64, rst, rdy, rd, rpc, hlt, res);
    m32 = step(m32, rst, rdy, rd, rpc, hlt, res);
    q64.push_back(view(m64));
    q32.push_back(view(m32));
    #1;
  endtask

  // Monitor: each cycle's registered outputs are compared on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q64.size() > 0) begin
      e = q64.pop_front();
      cmp("pc64", pc64, e.pc);
      cmp("valid64", 64'(vld64), 64'(e.vld));
      cmp("halted64", 64'(hlt64), 64'(e.hlt));
      cmp("misalign64", 64'(mis64), 64'(e.mis));
      cmp("maddr64", maddr64, e.maddr);
      cmp("cnt64", 64'(cnt64), 64'(e.cnt));
    end
    if (q32.size() > 0) begin
      e = q32.pop_front();
      cmp("pc32", 64'(pc32), e.pc);
      cmp("valid32", 64'(vld32), 64'(e.vld));
      cmp("halted32", 64'(hlt32), 64'(e.hlt));
      cmp("misalign32", 64'(mis32), 64'(e.mis));
      cmp("maddr32", 64'(maddr32), e.maddr);
      cmp("cnt32", 64'(cnt32), 64'(e.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m64 = '{booting: 1, halted: 0, pc: 0, mis: 0, maddr: 0, cnt: 0,
            mask: 64'hFFFF_FFFF_FFFF_FFFF, cmax: 65535, rvec: 64'h0};
    m32 = '{booting: 1, halted: 0, pc: 0, mis: 0, maddr: 0, cnt: 0,
            mask: 64'h0000_0000_FFFF_FFFF, cmax: 3, rvec: 64'hFFFF_FFFC};
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 64'h80, 1, 0);
    // Boot, then four accepts; 32-bit instance wraps from FFFF_FFFC and saturates.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 64'hDEAD_BEEF_C001_CAF0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 64'h20, 0, 0);
    cyc(0, 1, 1, 64'hDEAD_BEEF_C001_CAFE, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 64'h40, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 1, 64'h100, 0, 0);
    cyc(0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 64'h200, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r = r | 64'hFFFF_FFFF_FFFF_FF00;
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 5) == 0, r,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && (q64.size() > 0 || q32.size() > 0); i++) @(negedge clk);
    #1;
    if (q64.size() > 0 || q32.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", q64.size(), q32.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
